alu_arbiter: RTL and testbench

- Shares one WIDTH-bit ALU instance (ADD/SUB/AND/OR/NOT, flags Z/N/C/V) between two requesters.
- Uses round-robin arbitration with valid/ready request and response channels per requester.
- Registers operands and results, so each requester sees a clean, pipelined transaction interface.
- Sits between two independent issue engines and the shared combinational ALU.

---
 rtl/alu_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared WIDTH-bit ALU.
// Operands and results are registered, so each requester sees an IDLE -> EXEC -> RESP transaction.

module alu_arbiter_alu #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic             carry;
    logic             overflow;

    // SUB is A + ~B + 1, so carry-out of 1 means "no borrow".
    always_comb begin
        b_eff    = (opcode == OP_SUB) ? ~b : b;
        carry_in = (opcode == OP_SUB);
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
        flags = {(result == '0), result[WIDTH-1], carry, overflow};
    end

endmodule

// state | meaning
// IDLE  | arbitrating; ready offered to the granted requester
// EXEC  | latched operands drive the ALU; result captured into owner's rsp regs
// RESP  | owner's response held until its rsp_ready is sampled high
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [3:0]       rsp0_flags,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [3:0]       rsp1_flags,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             last_grant;
    logic             owner;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             grant;
    logic             accept;
    logic             rsp_done;

    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    alu_arbiter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .opcode (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req0_valid) begin
            grant = 1'b0;
        end else begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && (grant == 1'b0) && req0_valid;
    assign req1_ready = (state == IDLE) && (grant == 1'b1) && req1_valid;
    assign accept     = req0_ready || req1_ready;
    assign rsp_done   = owner ? rsp1_ready : rsp0_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else if (accept) begin
            last_grant <= grant;
            owner      <= grant;
            op_q       <= grant ? req1_opcode : req0_opcode;
            a_q        <= grant ? req1_a : req0_a;
            b_q        <= grant ? req1_b : req0_b;
        end
    end

    // Only the owner's response registers are ever written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_flags  <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_flags  <= '0;
        end else begin
            case (state)
                EXEC: begin
                    if (owner) begin
                        rsp1_valid  <= 1'b1;
                        rsp1_result <= alu_result;
                        rsp1_flags  <= alu_flags;
                    end else begin
                        rsp0_valid  <= 1'b1;
                        rsp0_result <= alu_result;
                        rsp0_flags  <= alu_flags;
                    end
                end
                RESP: begin
                    if (owner && rsp1_ready) begin
                        rsp1_valid <= 1'b0;
                    end
                    if (!owner && rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of full transactions plus
// hand-written backpressure and reset-abort sequences.

module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_opcode, req1_opcode;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_result, rsp1_result;
    logic [3:0] rsp0_flags, rsp1_flags;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_flags  (rsp0_flags),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_flags  (rsp1_flags),
        .busy        (busy)
    );

    typedef struct {
        logic       v0;
        logic [2:0] op0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic       v1;
        logic [2:0] op1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       owner;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_opcode = 3'b000; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_opcode = 3'b000; req1_a = 8'h00; req1_b = 8'h00;
    endtask

    // One full transaction; ends on an IDLE cycle after the response handshake.
    task automatic run_txn(input vec_t v, input int idx);
        int k;
        @(negedge clk);
        req0_valid = v.v0; req0_opcode = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_opcode = v.op1; req1_a = v.a1; req1_b = v.b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        k = 0;
        while (!(req0_ready || req1_ready) && k < 8) begin
            @(negedge clk); #1;
            k++;
        end
        check($sformatf("v%0d ready0", idx), {31'b0, req0_ready}, {31'b0, (v.owner == 1'b0)});
        check($sformatf("v%0d ready1", idx), {31'b0, req1_ready}, {31'b0, (v.owner == 1'b1)});
        @(negedge clk);
        idle_inputs();
        #1;
        check($sformatf("v%0d exec busy", idx), {31'b0, busy}, 32'd1);
        check($sformatf("v%0d exec rsp_valid", idx), {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        @(negedge clk);
        if (v.owner) begin
            check($sformatf("v%0d rsp1_valid", idx), {31'b0, rsp1_valid}, 32'd1);
            check($sformatf("v%0d rsp1_result", idx), {24'b0, rsp1_result}, {24'b0, v.res});
            check($sformatf("v%0d rsp1_flags", idx), {28'b0, rsp1_flags}, {28'b0, v.flg});
            check($sformatf("v%0d rsp0 quiet", idx), {31'b0, rsp0_valid}, 32'd0);
        end else begin
            check($sformatf("v%0d rsp0_valid", idx), {31'b0, rsp0_valid}, 32'd1);
            check($sformatf("v%0d rsp0_result", idx), {24'b0, rsp0_result}, {24'b0, v.res});
            check($sformatf("v%0d rsp0_flags", idx), {28'b0, rsp0_flags}, {28'b0, v.flg});
            check($sformatf("v%0d rsp1 quiet", idx), {31'b0, rsp1_valid}, 32'd0);
        end
        check($sformatf("v%0d resp busy", idx), {31'b0, busy}, 32'd1);
        @(negedge clk);
        check($sformatf("v%0d done idle", idx), {29'b0, busy, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            v0   op0     a0     b0    v1   op1     a1     b1   own  res    flags ZNCV
        vecs[0]  = '{1'b1, 3'b000, 8'hFF, 8'h01, 1'b1, 3'b010, 8'hF0, 8'h3C, 1'b0, 8'h00, 4'b1010};
        vecs[1]  = '{1'b1, 3'b000, 8'hFF, 8'h01, 1'b1, 3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000};
        vecs[2]  = '{1'b1, 3'b000, 8'h7F, 8'h01, 1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 8'h80, 4'b0101};
        vecs[3]  = '{1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b001, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1010};
        vecs[4]  = '{1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b001, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b0100};
        vecs[5]  = '{1'b1, 3'b110, 8'h12, 8'h34, 1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000};
        vecs[6]  = '{1'b1, 3'b100, 8'h00, 8'h55, 1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0100};
        vecs[7]  = '{1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b011, 8'h0F, 8'hA0, 1'b1, 8'hAF, 4'b0100};
        vecs[8]  = '{1'b1, 3'b001, 8'h80, 8'h01, 1'b1, 3'b000, 8'h80, 8'h80, 1'b0, 8'h7F, 4'b0011};
        vecs[9]  = '{1'b1, 3'b001, 8'h80, 8'h01, 1'b1, 3'b000, 8'h80, 8'h80, 1'b1, 8'h00, 4'b1011};
        vecs[10] = '{1'b1, 3'b001, 8'h80, 8'h01, 1'b1, 3'b000, 8'h80, 8'h80, 1'b0, 8'h7F, 4'b0011};
        vecs[11] = '{1'b1, 3'b001, 8'h80, 8'h01, 1'b1, 3'b000, 8'h80, 8'h80, 1'b1, 8'h00, 4'b1011};

        rst = 1'b1;
        idle_inputs();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        check("reset results", {rsp1_flags, rsp0_flags, rsp1_result, rsp0_result}, 32'd0);
        check("reset readies", {30'b0, req1_ready, req0_ready}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], i);
        end

        // Backpressure: req1 OR held pending while req0 waits and req1 re-requests.
        @(negedge clk);
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_opcode = 3'b011; req1_a = 8'h0F; req1_b = 8'hA0;
        #1;
        check("bp grant1", {30'b0, req1_ready, req0_ready}, 32'd2);
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 8'h01; req0_b = 8'h02;
        req1_a = 8'h11; req1_b = 8'h22;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp c%0d rsp1_valid", c), {31'b0, rsp1_valid}, 32'd1);
            check($sformatf("bp c%0d rsp1_result", c), {24'b0, rsp1_result}, 32'hAF);
            check($sformatf("bp c%0d readies", c), {30'b0, req1_ready, req0_ready}, 32'd0);
            check($sformatf("bp c%0d busy", c), {31'b0, busy}, 32'd1);
            @(negedge clk);
        end
        rsp1_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        check("bp rsp1 released", {31'b0, rsp1_valid}, 32'd0);
        check("bp req0 granted", {30'b0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("bp req0 result", {27'b0, rsp0_valid, rsp0_result}, 32'h103);
        check("bp req0 flags", {28'b0, rsp0_flags}, 32'd0);
        check("bp rsp1 untouched", {20'b0, rsp1_flags, rsp1_result}, 32'h4AF);
        @(negedge clk);

        // Reset in EXEC: transaction dropped, last_grant back to 1.
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 8'h10; req0_b = 8'h20;
        #1;
        check("rst grant0", {31'b0, req0_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("rst abort rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        check("rst abort busy", {31'b0, busy}, 32'd0);
        check("rst abort results", {rsp1_flags, rsp0_flags, rsp1_result, rsp0_result}, 32'd0);
        rst = 1'b0;
        req0_valid = 1'b1; req0_opcode = 3'b010; req0_a = 8'hFF; req0_b = 8'h0F;
        req1_valid = 1'b1; req1_opcode = 3'b000; req1_a = 8'h01; req1_b = 8'h01;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        check("rst tie grants req0", {30'b0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rst no stale rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        @(negedge clk);
        check("rst post result", {27'b0, rsp0_valid, rsp0_result}, 32'h10F);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
